// File: rtl/program_loader.sv
// Byte-stream program loader: takes a length-prefixed image, writes it to program
// memory from address 0 upward, and holds the CPU in reset until the load settles.
module program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int RST_HOLD   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  load_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  overflow,
  output logic [2:0]            state
);

  // Handshake: a byte moves on a rising edge where in_valid && in_ready. in_ready
  // depends only on the state, never on in_valid, so the source may hold in_valid
  // high freely and in_data is ignored whenever no transfer takes place.

  localparam logic [2:0] S_LEN_HI = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;

  localparam int              HOLD_W    = $clog2(RST_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [16:0]       DEPTH     = 17'd1 << ADDR_WIDTH;

  logic [2:0]        state_q;
  logic [2:0]        next_state;
  logic [7:0]        len_hi_q;
  logic [15:0]       len_q;
  logic [15:0]       count_q;
  logic [HOLD_W-1:0] hold_q;
  logic              xfer;
  logic              last_data;
  logic              in_range;
  logic [15:0]       hdr_len;

  assign state     = state_q;
  assign xfer      = in_valid && in_ready;
  assign hdr_len   = {len_hi_q, in_data};
  assign last_data = (count_q == len_q - 16'd1);
  // Bytes beyond the memory depth are still consumed to keep the stream framed.
  assign in_range  = ({1'b0, count_q} < DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LEN_HI;
    end else begin
      state_q <= next_state;
    end
  end

  always_comb begin
    next_state = state_q;
    case (state_q)
      S_LEN_HI: if (xfer) next_state = S_LEN_LO;
      S_LEN_LO: if (xfer) next_state = (hdr_len != 16'd0) ? S_DATA : S_HOLD;
      S_DATA:   if (xfer && last_data) next_state = S_HOLD;
      S_HOLD:   if (hold_q == HOLD_LAST) next_state = S_RUN;
      S_RUN:    if (load_req) next_state = S_LEN_HI;
      default:  next_state = S_LEN_HI;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    cpu_rst  = 1'b1;
    done     = 1'b0;
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA: in_ready = 1'b1;
      S_RUN: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: header capture, byte counter, registered write port, hold timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi_q  <= 8'd0;
      len_q     <= 16'd0;
      count_q   <= 16'd0;
      hold_q    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
      overflow  <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state_q)
        S_LEN_HI: if (xfer) len_hi_q <= in_data;
        S_LEN_LO: begin
          if (xfer) begin
            len_q    <= hdr_len;
            count_q  <= 16'd0;
            overflow <= 1'b0;
          end
        end
        S_DATA: begin
          if (xfer) begin
            count_q <= count_q + 16'd1;
            if (in_range) begin
              mem_we    <= 1'b1;
              mem_addr  <= count_q[ADDR_WIDTH-1:0];
              mem_wdata <= in_data;
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        default: ;
      endcase
      hold_q <= (state_q == S_HOLD) ? hold_q + HOLD_ONE : '0;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: drives length-prefixed frames and checks
// every write and the reset/run handshake against a frame-level model.
module tb_program_loader;

  localparam int AW       = 4;
  localparam int DEPTH    = 1 << AW;
  localparam int RST_HOLD = 3;
  localparam int W        = AW + 8;
  localparam logic [2:0] ST_LEN_HI = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          load_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          overflow;
  logic [2:0]    state;

  program_loader #(.ADDR_WIDTH(AW), .RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .load_req(load_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
    .done(done), .overflow(overflow), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic         last_ovf = 1'b0;
  logic [W-1:0] exp_q[$];
  int           exp_t[$];
  logic [7:0]   frame_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every mem_we must match the oldest expected write, on its cycle
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_we", 32'd1, 32'd0);
      end else begin
        check_eq("wr_addr_data", 32'({mem_addr, mem_wdata}), 32'(exp_q.pop_front()));
        check_eq("wr_cycle", cyc, exp_t.pop_front());
      end
    end
  end

  // driver: mode 0 = valid held, 1 = toggling valid, 2 = random valid
  task automatic send_bytes(input int mode);
    int idx   = 0;
    int step  = 0;
    int t;
    while (idx < frame_q.size()) begin
      @(negedge clk);
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (step % 2 == 0);
        default: in_valid = ($urandom_range(0, 1) == 1);
      endcase
      in_data  = in_valid ? frame_q[idx] : 8'($urandom_range(0, 255));
      load_req = ($urandom_range(0, 7) == 0);
      t = cyc + 1;
      check_eq("frame_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      if (in_valid) begin
        if (idx >= 2 && (idx - 2) < DEPTH) begin
          exp_q.push_back(W'({4'(idx - 2), frame_q[idx]}));
          exp_t.push_back(t);
        end
        idx++;
      end
      step++;
      if (step > 2000) begin
        check_eq("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  task automatic finish_frame(input int len);
    for (int k = 1; k <= RST_HOLD; k++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 1) == 1);
      in_data  = 8'($urandom_range(0, 255));
      load_req = ($urandom_range(0, 1) == 1);
      check_eq("hold_cpu_rst", 32'(cpu_rst), 32'd1);
      check_eq("hold_done", 32'(done), 32'd0);
      check_eq("hold_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    load_req = 1'b0;
    last_ovf = (len > DEPTH);
    check_eq("run_cpu_rst", 32'(cpu_rst), 32'd0);
    check_eq("run_done", 32'(done), 32'd1);
    check_eq("run_ready", 32'(in_ready), 32'd0);
    check_eq("run_state", 32'(state), 32'(ST_RUN));
    check_eq("run_overflow", 32'(overflow), 32'(last_ovf));
    check_eq("run_pending_wr", exp_q.size(), 0);
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 1) == 1);
      check_eq("run_stays", 32'({done, cpu_rst, overflow}), 32'({2'b10, last_ovf}));
    end
  endtask

  task automatic reload();
    @(negedge clk);
    in_valid = 1'b0;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check_eq("reload_cpu_rst", 32'(cpu_rst), 32'd1);
    check_eq("reload_done", 32'(done), 32'd0);
    check_eq("reload_ready", 32'(in_ready), 32'd1);
    check_eq("reload_state", 32'(state), 32'(ST_LEN_HI));
    check_eq("reload_ovf_held", 32'(overflow), 32'(last_ovf));
  endtask

  task automatic build_frame(input int len, input bit rnd);
    frame_q.delete();
    frame_q.push_back(8'(len >> 8));
    frame_q.push_back(8'(len));
    for (int i = 0; i < len; i++)
      frame_q.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(i + 1));
  endtask

  task automatic run_frame(input int mode);
    int len = {frame_q[0], frame_q[1]};
    send_bytes(mode);
    finish_frame(len);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; load_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_state", 32'(state), 32'(ST_LEN_HI));
    check_eq("rst_outputs", 32'({cpu_rst, in_ready, mem_we, done, overflow}), 32'b11000);
    check_eq("rst_addr_data", 32'({mem_addr, mem_wdata}), 32'd0);
    rst = 1'b0;

    // basic, throttled and zero-length frames
    frame_q = '{8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    run_frame(0);
    reload();
    frame_q = '{8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    run_frame(1);
    reload();
    frame_q = '{8'h00, 8'h00};
    run_frame(0);

    // depth boundary: exactly full, one over, well over
    reload(); build_frame(DEPTH, 1'b1);     run_frame(0);
    reload(); build_frame(DEPTH + 1, 1'b1); run_frame(2);
    reload(); build_frame(DEPTH + 4, 1'b0); run_frame(0);

    // reload after overflow clears it
    reload();
    frame_q = '{8'h00, 8'h01, 8'h5A};
    run_frame(0);

    // reset mid-load after 2 of 4 data bytes
    reload();
    frame_q = '{8'h00, 8'h04, 8'h11, 8'h22};
    send_bytes(0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_ovf = 1'b0;
    check_eq("midrst_state", 32'(state), 32'(ST_LEN_HI));
    check_eq("midrst_outputs", 32'({cpu_rst, mem_we, done, in_ready, overflow}), 32'b10010);
    check_eq("midrst_pending", exp_q.size(), 0);
    frame_q = '{8'h00, 8'h02, 8'h33, 8'h44};
    run_frame(2);

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      reload();
      build_frame($urandom_range(0, DEPTH + 8), 1'b1);
      run_frame($urandom_range(0, 2));
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Streams a program image into the CPU's program memory over a byte stream. It writes each byte to sequential addresses starting at 0, holding the CPU in reset throughout. When the load completes, it keeps reset asserted for RST_HOLD further cycles, then releases the CPU to run. It is the writer-side counterpart of the CPU's program-memory reader and replaces file preloading on hardware.

Parameters:
ADDR_WIDTH, 8, program memory address width; depth = 2^ADDR_WIDTH bytes
RST_HOLD, 3, cycles cpu_rst stays high after the last write (minimum 1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  byte on in_data is valid
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle
load_req  input  1  single-cycle pulse; starts a new load from RUN
mem_we  output  1  program memory write strobe
mem_addr  output  ADDR_WIDTH  write address
mem_wdata  output  8  write data
cpu_rst  output  1  reset to CPU; active-high
done  output  1  high while in RUN
overflow  output  1  sticky; image exceeded memory depth

Behaviour:
- Reset (rst=1 at edge): state=LEN_HI; cpu_rst=1, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0, overflow=0; length and byte counters = 0. rst mid-load aborts the load; bytes already written are not undone.
- A byte transfers on an edge where in_valid && in_ready. in_ready is combinational from state: 1 in LEN_HI, LEN_LO, DATA; 0 otherwise. in_data is ignored when no transfer occurs.
- Frame format: length high byte, length low byte (16-bit LEN, big-endian), then LEN data bytes.
- States:
  - LEN_HI: on transfer, latch LEN[15:8] -> LEN_LO.
  - LEN_LO: on transfer, latch LEN[7:0]; clear byte counter; clear overflow. Go to DATA if LEN != 0, else to HOLD.
  - DATA: on transfer with count < 2^ADDR_WIDTH, the next cycle has mem_we=1, mem_addr=count[ADDR_WIDTH-1:0], and mem_wdata=byte (registered, 1-cycle latency). With count >= 2^ADDR_WIDTH, the byte is accepted and discarded, mem_we stays 0, and overflow is set to 1. count increments on every transfer. When count reaches LEN-1 on a transfer, go to HOLD.
  - HOLD: cpu_rst=1; a hold counter runs RST_HOLD cycles, then go to RUN. The final mem_we pulse lands in the first HOLD cycle.
  - RUN: cpu_rst=0 and done=1 from the first RUN cycle. load_req=1 goes to LEN_HI with cpu_rst=1 on the next cycle; mem contents are untouched until new writes arrive.
- load_req is ignored in every state except RUN.
- mem_we is 0 in every cycle that does not follow a DATA transfer. Back-to-back transfers produce back-to-back writes at consecutive addresses.
- Address never wraps: writes stop at address 2^ADDR_WIDTH-1. Excess bytes are consumed so the stream stays framed.
- cpu_rst is 1 in every state except RUN.
- overflow holds its value through RUN. It clears only on rst or at the next LEN_LO transfer.

Test Plan:
1. Basic load: rst 1 cycle, then stream 00 03 AA BB CC with in_valid held high. Expect writes (0,AA), (1,BB), (2,CC) on 3 consecutive cycles. cpu_rst falls exactly 3 cycles after the last accepted byte's write cycle; done=1; overflow=0.
2. Throttled source: same frame with in_valid toggling 1/0 each cycle. Expect writes only after accepted bytes, and identical addresses and data to test 1.
3. Zero length: stream 00 00. Expect no mem_we; HOLD lasts 3 cycles, then cpu_rst=0 and done=1.
4. Overflow (ADDR_WIDTH=2): stream 00 06 01 02 03 04 05 06. Expect writes to addresses 0-3 with 01-04 only. in_ready stays 1 for all 6 data bytes; overflow=1; RUN is reached.
5. Reload: in RUN pulse load_req. Expect cpu_rst=1, done=0, in_ready=1 the next cycle. Stream 00 01 5A: expect write (0,5A), overflow cleared, then RUN.
6. Reset mid-load: assert rst after 2 of 4 data bytes. Expect state LEN_HI, cpu_rst=1, mem_we=0. The next byte is treated as LEN_HI and no further writes occur until a full header is received.
